// File: rtl/onoff_arb_pkg.sv
// Shared definitions for the ON/OFF resource arbiter.
// Provides the FSM state encoding used by onoff_resource_arbiter.
package onoff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_e;

endpackage

// File: rtl/onoff_resource_arbiter_rr_pick.sv
// Combinational round-robin pick.
// Ports:
//   req   - per-requester request vector
//   ptr   - index with highest priority this round
//   valid - at least one request is set
//   idx   - first set request at or after ptr, wrapping mod N
module rr_pick #(
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic          valid,
  output logic [CW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [CW-1:0] off;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the
  // rotation. ptr is always kept below N by the arbiter.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(ptr)) % N];
    end
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = CW'(i);
    end
    valid = |rot;
    idx   = CW'((int'(off) + int'(ptr)) % N);
  end

endmodule

// File: rtl/onoff_resource_arbiter.sv
// Round-robin arbiter sharing one ON/OFF resource between N requesters.
// Each ownership lasts until the owner drops its request or HOLD_MAX grant
// cycles elapse; one guard cycle separates consecutive owners so the
// resource is OFF before the next grant.
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-low reset
//   req     - per-requester level request, held until done
//   gnt     - registered one-hot grant
//   owner   - index of current or most recent owner
//   busy    - resource ON (grant in progress)
//   timeout - one-cycle pulse when ownership is revoked by HOLD_MAX
module onoff_resource_arbiter
  import onoff_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 16,
  parameter int CW       = (N > 1) ? $clog2(N) : 1,
  parameter int HW       = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] owner,
  output logic          busy,
  output logic          timeout
);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [CW-1:0] owner_q, owner_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic          pick_valid;
  logic [CW-1:0] pick_idx;

  rr_pick #(.N(N), .CW(CW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = GRANT;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = HW'(1);
        end
      end
      GRANT: begin
        // Release wins over timeout when both happen on the same cycle.
        if (!req[owner_q] || (cnt_q == HW'(HOLD_MAX))) begin
          state_d   = GUARD;
          gnt_d     = '0;
          timeout_d = req[owner_q];
          ptr_d     = (owner_q == CW'(N - 1)) ? '0 : owner_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_onoff_resource_arbiter.sv
module tb_onoff_resource_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  logic [3:0] req16;
  logic [3:0] gnt16;
  logic [1:0] owner16;
  logic       busy16;
  logic       to16;

  int n_cmp = 0;
  int n_bad = 0;

  onoff_resource_arbiter #(.N(4), .HOLD_MAX(3)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  onoff_resource_arbiter #(.N(4), .HOLD_MAX(16)) u_dut16 (
    .clk     (clk),
    .reset   (reset),
    .req     (req16),
    .gnt     (gnt16),
    .owner   (owner16),
    .busy    (busy16),
    .timeout (to16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant, busy and timeout of the HOLD_MAX=3 instance.
  task automatic chk_a(input string tag, input logic [3:0] eg, input logic eb, input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b1111;
    req16 = 4'b0000;
    #3;
    chk_a("reset_async", 4'b0000, 1'b0, 1'b0);
    chk("reset_owner", 32'(owner), 32'd0);
    step;
    step;
    chk_a("reset_clocked", 4'b0000, 1'b0, 1'b0);

    reset = 1'b1;
    step;
    chk_a("first_grant", 4'b0001, 1'b1, 1'b0);

    // All four requesting: 3-cycle grants, timeout, then GUARD and IDLE.
    for (int g = 0; g < 5; g++) begin
      logic [3:0] eg;
      eg = 4'(1 << (g % 4));
      for (int c = 0; c < 3; c++) begin
        chk_a("rr_grant", eg, 1'b1, 1'b0);
        chk("rr_owner", 32'(owner), 32'(g % 4));
        step;
      end
      chk_a("rr_guard", 4'b0000, 1'b0, 1'b1);
      chk("rr_guard_owner", 32'(owner), 32'(g % 4));
      step;
      chk_a("rr_idle", 4'b0000, 1'b0, 1'b0);
      step;
    end
    // Owner 1 now holds; drop everything.
    chk_a("rr_next", 4'b0010, 1'b1, 1'b0);
    req = 4'b0000;
    step;
    chk_a("rel_guard", 4'b0000, 1'b0, 1'b0);
    chk("rel_owner", 32'(owner), 32'd1);
    step;

    // ptr=2: grant 2, release, then 0101 must wrap past 3 to 0, then 2.
    req = 4'b0100;
    step;
    chk_a("wrap_g2", 4'b0100, 1'b1, 1'b0);
    req = 4'b0000;
    step;
    chk_a("wrap_g2_rel", 4'b0000, 1'b0, 1'b0);
    chk("wrap_g2_owner", 32'(owner), 32'd2);
    step;
    req = 4'b0101;
    step;
    chk_a("wrap_g0", 4'b0001, 1'b1, 1'b0);
    chk("wrap_g0_owner", 32'(owner), 32'd0);
    step;
    step;
    step;
    chk_a("wrap_g0_to", 4'b0000, 1'b0, 1'b1);
    step;
    step;
    chk_a("wrap_skip_g2", 4'b0100, 1'b1, 1'b0);
    chk("wrap_skip_owner", 32'(owner), 32'd2);
    req = 4'b0000;
    step;
    step;

    // ptr=3: owner 1 drops request in the cycle cnt reaches HOLD_MAX.
    req = 4'b0010;
    step;
    chk_a("simul_c1", 4'b0010, 1'b1, 1'b0);
    step;
    step;
    chk_a("simul_c3", 4'b0010, 1'b1, 1'b0);
    req = 4'b0000;
    step;
    chk_a("simul_guard", 4'b0000, 1'b0, 1'b0);
    chk("simul_owner", 32'(owner), 32'd1);
    step;
    chk_a("simul_idle", 4'b0000, 1'b0, 1'b0);

    // ptr=2: owner 3, then async reset between edges.
    req = 4'b1000;
    step;
    chk_a("mid_grant", 4'b1000, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_a("mid_reset", 4'b0000, 1'b0, 1'b0);
    chk("mid_reset_owner", 32'(owner), 32'd0);
    step;
    reset = 1'b1;
    req   = 4'b1111;
    step;
    chk_a("restart_ptr0", 4'b0001, 1'b1, 1'b0);
    req = 4'b0000;
    step;
    step;

    // Single requester on the HOLD_MAX=16 instance: 5 cycles, no timeout.
    req16 = 4'b0100;
    step;
    for (int c = 0; c < 5; c++) begin
      chk("single_gnt", 32'(gnt16), 32'(4'b0100));
      chk("single_to", 32'(to16), 32'd0);
      if (c < 4) step;
    end
    req16 = 4'b0000;
    step;
    chk("single_guard_gnt", 32'(gnt16), 32'd0);
    chk("single_guard_busy", 32'(busy16), 32'd0);
    chk("single_guard_to", 32'(to16), 32'd0);
    chk("single_owner", 32'(owner16), 32'd2);
    step;
    chk("single_idle_gnt", 32'(gnt16), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
